reaction_controller: RTL and testbench
======================================

REACTION_CONTROLLER -- requirements
Module: reaction_controller

Interface
REQ-001 Parameter MIN_DELAY_MS, default 1000, minimum random wait before GO, in ms.
REQ-002 Parameter SPAN_BITS, default 12, width of the random delay addend (addend range 0..2^SPAN_BITS-1).
REQ-003 Parameter TIMEOUT_MS, default 9999, maximum GO duration before forced finish.
REQ-004 Port clk, input, 1, system clock; single clock domain.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port tick_1ms, input, 1, one-clk-wide strobe once per millisecond, synchronous to clk.
REQ-007 Port start_key, input, 1, debounced start button, high = pressed, asynchronous to clk.
REQ-008 Port stop_key, input, 1, debounced reaction button, high = pressed, asynchronous to clk.
REQ-009 Port en_reaction_counter, output, 1, high while the reaction counter shall count.
REQ-010 Port clear_counter, output, 1, one-clk pulse zeroing the downstream counter.
REQ-011 Port led_go, output, 1, GO lamp.
REQ-012 Port result_valid, output, 1, high while a finished result is held.
REQ-013 Port false_start, output, 1, high when stop was pressed before GO.
REQ-014 Port timed_out, output, 1, high when GO reached TIMEOUT_MS without stop.
REQ-015 Port state_o, output, 3, current FSM state encoding for debug LEDs.

Function
REQ-016 start_key and stop_key shall each pass a 2-flop synchroniser; start acts on the synchronised rising edge only; stop acts on synchronised level.
REQ-017 A 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, shall advance every clk, never reaching all-zero.
REQ-018 States: IDLE, ARM, DELAY, GO, DONE, EARLY (6 states).
REQ-019 IDLE: all outputs low except state_o; start edge -> ARM.
REQ-020 ARM (one clk): load delay_cnt = MIN_DELAY_MS + LFSR[SPAN_BITS-1:0], pulse clear_counter, clear all flags -> DELAY.
REQ-021 DELAY: decrement delay_cnt on each tick_1ms; at delay_cnt==1 with tick -> GO next clk; stop level high in any DELAY cycle -> EARLY (stop beats tick in the same cycle).
REQ-022 GO: led_go=1 and en_reaction_counter=1 from the first GO clk; go_cnt counts ticks from 0.
REQ-023 GO: stop high -> DONE next clk; en_reaction_counter drops in that same next clk (1-clk latency).
REQ-024 GO: go_cnt reaching TIMEOUT_MS on a tick -> DONE with timed_out=1; if stop and the terminal tick coincide, stop wins, timed_out=0.
REQ-025 DONE: result_valid=1, led_go=0, en=0; start edge -> ARM (new round).
REQ-026 EARLY: false_start=1, led_go=0, en=0; start edge -> ARM.
REQ-027 A start edge in DELAY or GO shall be ignored.
REQ-028 delay_cnt 14 bits and go_cnt 14 bits, unsigned; no wrap possible within parameter defaults.
REQ-029 stop_key held high through ARM shall yield EARLY on the first DELAY clk.

Reset
REQ-030 rst_n low asynchronously forces IDLE, all outputs 0, counters 0, LFSR to seed, synchronisers 0.
REQ-031 Reset release is synchronised in-block; reset mid-round abandons the round with no clear_counter pulse.

Structure
REQ-032 Package reaction_pkg holds the state enumeration, LFSR seed and tap constants, and default timing constants.
REQ-033 LFSR shall be sub-module lfsr16 (clk, rst_n, value[15:0]); all else in reaction_controller.

Verification
REQ-034 Reset, start edge, LFSR[11:0]=0 at ARM -> exactly 1000 ticks in DELAY, then led_go=1, en=1.
REQ-035 In GO, stop high after 250 ticks -> en low 1 clk later, result_valid=1, timed_out=0, false_start=0.
REQ-036 stop high during DELAY tick 500 -> EARLY, false_start=1, led_go never asserted.
REQ-037 No stop in GO -> after 9999 ticks DONE, timed_out=1; stop on tick 9999 -> timed_out=0.
REQ-038 rst_n low mid-GO -> all outputs 0 immediately (async); start edge in GO -> no state change.
REQ-039 Two consecutive rounds -> clear_counter pulses exactly once per ARM; delays differ (LFSR advanced).

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared constants for the reaction-time game controller: FSM encodings,
// LFSR seed/taps and default timing.
package reaction_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_DELAY = 3'd2;
  localparam logic [2:0] ST_GO    = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_EARLY = 3'd5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_MIN_DELAY_MS = 1000;
  localparam int DEF_SPAN_BITS    = 12;
  localparam int DEF_TIMEOUT_MS   = 9999;
  localparam int CNT_W            = 14;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a non-zero seed keeps it out of the
// all-zero lock-up state.
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] value
);

  // Advance one step per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_SEED;
    end else begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/reaction_controller.sv
// Reaction-time game sequencer: random wait, GO lamp, reaction window with
// timeout, and false-start detection.
module reaction_controller
  import reaction_pkg::*;
#(
  parameter int MIN_DELAY_MS = DEF_MIN_DELAY_MS,
  parameter int SPAN_BITS    = DEF_SPAN_BITS,
  parameter int TIMEOUT_MS   = DEF_TIMEOUT_MS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1ms,
  input  logic       start_key,
  input  logic       stop_key,
  output logic       en_reaction_counter,
  output logic       clear_counter,
  output logic       led_go,
  output logic       result_valid,
  output logic       false_start,
  output logic       timed_out,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] L_MIN_DELAY = CNT_W'(MIN_DELAY_MS);
  localparam logic [CNT_W-1:0] L_TIMEOUT   = CNT_W'(TIMEOUT_MS);
  localparam logic [15:0]      L_SPAN_MASK = 16'((32'd1 << SPAN_BITS) - 32'd1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [1:0]       r_start_sync;
  logic             r_start_d;
  logic [1:0]       r_stop_sync;
  logic             w_start_edge;
  logic             w_stop;
  logic [15:0]      w_lfsr;
  logic [CNT_W-1:0] w_delay_load;
  logic [CNT_W-1:0] w_go_inc;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_delay_cnt;
  logic [CNT_W-1:0] r_go_cnt;
  logic             r_en;
  logic             r_clear;
  logic             r_led_go;
  logic             r_result_valid;
  logic             r_false_start;
  logic             r_timed_out;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_delay_nxt;
  logic [CNT_W-1:0] w_go_nxt;
  logic             w_timeout_hit;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Two-flop synchronisers for the asynchronous buttons.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_start_sync <= 2'b00;
      r_start_d    <= 1'b0;
      r_stop_sync  <= 2'b00;
    end else begin
      r_start_sync <= {r_start_sync[0], start_key};
      r_start_d    <= r_start_sync[1];
      r_stop_sync  <= {r_stop_sync[0], stop_key};
    end
  end

  assign w_start_edge = r_start_sync[1] & ~r_start_d;
  assign w_stop       = r_stop_sync[1];

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (w_rst_n),
    .value (w_lfsr)
  );

  assign w_delay_load = L_MIN_DELAY + CNT_W'(w_lfsr & L_SPAN_MASK);
  assign w_go_inc     = r_go_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and counter update; stop always outranks a coincident tick.
  always_comb begin
    w_state_nxt   = r_state;
    w_delay_nxt   = r_delay_cnt;
    w_go_nxt      = r_go_cnt;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_EARLY: begin
        if (w_start_edge) begin
          w_state_nxt = ST_ARM;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_ARM: begin
        w_delay_nxt = w_delay_load;
        w_go_nxt    = {CNT_W{1'b0}};
        w_state_nxt = ST_DELAY;
      end
      ST_DELAY: begin
        if (w_stop) begin
          w_state_nxt = ST_EARLY;
        end else if (tick_1ms) begin
          if (r_delay_cnt <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
            w_state_nxt = ST_GO;
          end else begin
            w_delay_nxt = r_delay_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          w_state_nxt = ST_DELAY;
        end
      end
      ST_GO: begin
        if (w_stop) begin
          w_state_nxt = ST_DONE;
        end else if (tick_1ms) begin
          w_go_nxt = w_go_inc;
          if (w_go_inc == L_TIMEOUT) begin
            w_state_nxt   = ST_DONE;
            w_timeout_hit = 1'b1;
          end else begin
            w_state_nxt = ST_GO;
          end
        end else begin
          w_state_nxt = ST_GO;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and outputs are all registered from the next state.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state        <= ST_IDLE;
      r_delay_cnt    <= {CNT_W{1'b0}};
      r_go_cnt       <= {CNT_W{1'b0}};
      r_en           <= 1'b0;
      r_clear        <= 1'b0;
      r_led_go       <= 1'b0;
      r_result_valid <= 1'b0;
      r_false_start  <= 1'b0;
      r_timed_out    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_delay_cnt    <= w_delay_nxt;
      r_go_cnt       <= w_go_nxt;
      r_en           <= (w_state_nxt == ST_GO);
      r_clear        <= (w_state_nxt == ST_ARM);
      r_led_go       <= (w_state_nxt == ST_GO);
      r_result_valid <= (w_state_nxt == ST_DONE);
      r_false_start  <= (w_state_nxt == ST_EARLY);
      r_timed_out    <= (w_state_nxt == ST_DONE) &&
                        (w_timeout_hit || ((r_state == ST_DONE) && r_timed_out));
    end
  end

  assign en_reaction_counter = r_en;
  assign clear_counter       = r_clear;
  assign led_go              = r_led_go;
  assign result_valid        = r_result_valid;
  assign false_start         = r_false_start;
  assign timed_out           = r_timed_out;
  assign state_o             = r_state;

endmodule

// File: tb/tb_reaction_controller.sv
// Directed bench for reaction_controller: tick_1ms is held high so every clock
// is a millisecond; outputs are sampled on the falling edge.
module tb_reaction_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1ms = 1'b0;
  logic       start_key = 1'b0;
  logic       stop_key = 1'b0;
  logic       en_reaction_counter;
  logic       clear_counter;
  logic       led_go;
  logic       result_valid;
  logic       false_start;
  logic       timed_out;
  logic [2:0] state_o;

  int          n_tests = 0;
  int          n_fail = 0;
  int          clr_cnt = 0;
  logic        go_seen = 1'b0;
  int          ecnt = 0;
  logic [15:0] mlfsr = 16'hACE1;

  reaction_controller dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .tick_1ms            (tick_1ms),
    .start_key           (start_key),
    .stop_key            (stop_key),
    .en_reaction_counter (en_reaction_counter),
    .clear_counter       (clear_counter),
    .led_go              (led_go),
    .result_valid        (result_valid),
    .false_start         (false_start),
    .timed_out           (timed_out),
    .state_o             (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSR: internal reset lifts two clocks after rst_n rises.
  always @(posedge clk) begin
    if (!rst_n) begin
      ecnt  <= 0;
      mlfsr <= 16'hACE1;
    end else begin
      ecnt <= ecnt + 1;
      if (ecnt >= 2) mlfsr <= ref_step(mlfsr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    clr_cnt += int'(clear_counter);
    if (led_go) go_seen = 1'b1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({en_reaction_counter, clear_counter, led_go, result_valid,
                false_start, timed_out, state_o});
  endfunction

  // Press start and stop at the ARM cycle; returns the delay the model predicts.
  task automatic arm(input string tag, output int exp_d);
    int n;
    n = 0;
    start_key = 1'b1;
    do begin
      cyc();
      n++;
    end while (!clear_counter && n < 20);
    check({tag, "_clear_pulse"}, 32'(clear_counter), 32'd1);
    check({tag, "_state_arm"}, 32'(state_o), 32'd1);
    exp_d = 1000 + int'(mlfsr[11:0]);
    start_key = 1'b0;
  endtask

  // Count DELAY cycles until the GO lamp lights.
  task automatic measure(input string tag, input int exp_d, output int got_d);
    int n;
    n = 0;
    forever begin
      cyc();
      if (led_go || n >= 6000) break;
      n++;
    end
    got_d = n;
    check({tag, "_delay_ticks"}, 32'(n), 32'(exp_d));
    check({tag, "_go_lamp"}, 32'({led_go, en_reaction_counter}), 32'd3);
    check({tag, "_state_go"}, 32'(state_o), 32'd3);
  endtask

  initial begin
    int c0;
    int ed;
    int da;
    int dc;
    int dd;
    int n;

    // Reset
    cycles(3);
    check("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    cycles(5);
    check("idle_outputs", all_outs(), 32'd0);
    tick_1ms = 1'b1;

    // Round A: react after ~250 ticks; start presses in GO are ignored
    c0 = clr_cnt;
    arm("A", ed);
    measure("A", ed, da);
    start_key = 1'b1;
    cycles(6);
    start_key = 1'b0;
    check("A_start_in_go", 32'({led_go, state_o}), 32'({1'b1, 3'd3}));
    cycles(241);
    stop_key = 1'b1;
    cycles(2);
    check("A_en_before_stop", 32'(en_reaction_counter), 32'd1);
    cyc();
    check("A_done_flags", 32'({en_reaction_counter, led_go, result_valid, false_start, timed_out}),
          32'(5'b00100));
    check("A_state_done", 32'(state_o), 32'd4);
    check("A_one_clear", 32'(clr_cnt - c0), 32'd1);
    stop_key = 1'b0;
    cycles(3);

    // Round B: stop during DELAY tick 500
    c0 = clr_cnt;
    arm("B", ed);
    go_seen = 1'b0;
    cycles(498);
    stop_key = 1'b1;
    cycles(2);
    check("B_still_delay", 32'(state_o), 32'd2);
    cyc();
    check("B_state_early", 32'(state_o), 32'd5);
    check("B_flags", 32'({false_start, result_valid, led_go, en_reaction_counter}), 32'(4'b1000));
    check("B_go_never", 32'(go_seen), 32'd0);
    check("B_one_clear", 32'(clr_cnt - c0), 32'd1);

    // Stop held through ARM gives EARLY straight after the first DELAY clock
    c0 = clr_cnt;
    arm("S", ed);
    cyc();
    check("S_first_delay", 32'(state_o), 32'd2);
    cyc();
    check("S_early", 32'({false_start, state_o}), 32'({1'b1, 3'd5}));
    check("S_one_clear", 32'(clr_cnt - c0), 32'd1);
    stop_key = 1'b0;
    cycles(3);

    // Round C: no reaction, timeout after 9999 ticks
    c0 = clr_cnt;
    arm("C", ed);
    measure("C", ed, dc);
    check("C_delay_differs", 32'(dc != da), 32'd1);
    n = 1;
    forever begin
      cyc();
      if (!led_go || n >= 10100) break;
      n++;
    end
    check("C_go_ticks", 32'(n), 32'd9999);
    check("C_timeout_flags", 32'({timed_out, result_valid, en_reaction_counter}), 32'(3'b110));
    check("C_state_done", 32'(state_o), 32'd4);
    check("C_one_clear", 32'(clr_cnt - c0), 32'd1);

    // Round D: stop coincides with the terminal tick
    arm("D", ed);
    measure("D", ed, dd);
    cycles(9996);
    stop_key = 1'b1;
    cycles(2);
    check("D_go_at_9999", 32'(led_go), 32'd1);
    cyc();
    check("D_stop_wins", 32'({timed_out, result_valid, state_o}), 32'({1'b0, 1'b1, 3'd4}));
    stop_key = 1'b0;
    cycles(3);

    // Round E: asynchronous reset in the middle of GO
    arm("E", ed);
    measure("E", ed, dd);
    cycles(10);
    #2 rst_n = 1'b0;
    #1 check("E_async_reset", all_outs(), 32'd0);
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
